// File: rtl/hyperbus_cs_sequencer.sv
// ============================================================================
// hyperbus_cs_sequencer: N-chip CS / output-clock-enable sequencer with
// programmable tCSS, tCSH and tCSHI intervals, in the tx_clk_90 domain.
// Optional tCSM watchdog: define HYPERBUS_CS_TCSM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hyperbus_cs_sequencer #(
  parameter int unsigned NumChips  = 2,
  parameter int unsigned CntWidth  = 4,
  parameter int unsigned TcsmWidth = 12
) (
  input  logic                 tx_clk_90,
  input  logic                 rst_ni,
  input  logic [NumChips-1:0]  cs_i,
  input  logic                 cs_ena_i,
  input  logic                 ck_req_i,
  input  logic [CntWidth-1:0]  cfg_t_css_i,
  input  logic [CntWidth-1:0]  cfg_t_csh_i,
  input  logic [CntWidth-1:0]  cfg_t_cshi_i,
  input  logic [TcsmWidth-1:0] cfg_t_csm_i,
  output logic [NumChips-1:0]  hyper_cs_no,
  output logic                 ck_ena_o,
  output logic                 cs_ready_o,
  output logic                 busy_o,
  output logic                 sel_err_o,
  output logic                 tcsm_viol_o
);

  localparam logic [CntWidth-1:0] CntOne = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACTIVE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [NumChips-1:0] sel_q, sel_d;
  logic [NumChips-1:0] cs_n_q, cs_n_d;
  logic                ck_ena_q, ck_ena_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      cs_n_q   <= '1;
      ck_ena_q <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cs_n_q   <= cs_n_d;
      ck_ena_q <= ck_ena_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    ck_ena_d = 1'b0;
    rdy_d    = rdy_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        rdy_d = 1'b0;
        if (cs_ena_i) begin
          if ($onehot(cs_i)) begin
            sel_d   = cs_i;
            cnt_d   = cfg_t_css_i;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        // An aborted setup goes straight to hold so tCSH is still honoured
        if (!cs_ena_i) begin
          cnt_d   = cfg_t_csh_i;
          state_d = HOLD;
        end else if (cnt_q == '0) begin
          rdy_d   = 1'b1;
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      ACTIVE: begin
        if (!cs_ena_i) begin
          rdy_d   = 1'b0;
          cnt_d   = cfg_t_csh_i;
          state_d = HOLD;
        end else begin
          ck_ena_d = ck_req_i;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = cfg_t_cshi_i;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cs_n_d = (state_d inside {SETUP, ACTIVE, HOLD}) ? ~sel_d : '1;
    busy_d = (state_d != IDLE);
  end

  assign hyper_cs_no = cs_n_q;
  assign ck_ena_o    = ck_ena_q;
  assign cs_ready_o  = rdy_q;
  assign busy_o      = busy_q;
  assign sel_err_o   = err_q;

`ifdef HYPERBUS_CS_TCSM_EN
  localparam logic [TcsmWidth-1:0] TcsmOne = 1;

  logic [TcsmWidth-1:0] tcsm_q, tcsm_d;
  logic                 viol_q, viol_d;

  always_comb begin
    tcsm_d = tcsm_q;
    viol_d = viol_q;
    if (state_q == IDLE && state_d == SETUP) begin
      tcsm_d = '0;
      viol_d = 1'b0;
    end else if (state_q inside {SETUP, ACTIVE, HOLD}) begin
      if (tcsm_q != '1) begin
        tcsm_d = tcsm_q + TcsmOne;
      end
      // Flag only; CS is left under controller control
      if (cfg_t_csm_i != '0 && tcsm_d == cfg_t_csm_i) begin
        viol_d = 1'b1;
      end
    end
  end

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      tcsm_q <= '0;
      viol_q <= 1'b0;
    end else begin
      tcsm_q <= tcsm_d;
      viol_q <= viol_d;
    end
  end

  assign tcsm_viol_o = viol_q;
`else
  logic unused_csm;
  assign unused_csm  = ^cfg_t_csm_i;
  assign tcsm_viol_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hyperbus_cs_sequencer.sv
// ============================================================================
// tb_hyperbus_cs_sequencer: table-driven bench plus directed multi-cycle
// sequences for abort-in-setup, async reset in hold and the tCSM watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hyperbus_cs_sequencer;

  logic        tx_clk_90 = 1'b0;
  logic        rst_ni;
  logic [1:0]  cs_i;
  logic        cs_ena_i;
  logic        ck_req_i;
  logic [3:0]  cfg_t_css_i;
  logic [3:0]  cfg_t_csh_i;
  logic [3:0]  cfg_t_cshi_i;
  logic [11:0] cfg_t_csm_i;
  logic [1:0]  hyper_cs_no;
  logic        ck_ena_o;
  logic        cs_ready_o;
  logic        busy_o;
  logic        sel_err_o;
  logic        tcsm_viol_o;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef HYPERBUS_CS_TCSM_EN
  localparam bit TcsmOn = 1'b1;
`else
  localparam bit TcsmOn = 1'b0;
`endif

  hyperbus_cs_sequencer #(
    .NumChips (2),
    .CntWidth (4),
    .TcsmWidth(12)
  ) dut (
    .tx_clk_90   (tx_clk_90),
    .rst_ni      (rst_ni),
    .cs_i        (cs_i),
    .cs_ena_i    (cs_ena_i),
    .ck_req_i    (ck_req_i),
    .cfg_t_css_i (cfg_t_css_i),
    .cfg_t_csh_i (cfg_t_csh_i),
    .cfg_t_cshi_i(cfg_t_cshi_i),
    .cfg_t_csm_i (cfg_t_csm_i),
    .hyper_cs_no (hyper_cs_no),
    .ck_ena_o    (ck_ena_o),
    .cs_ready_o  (cs_ready_o),
    .busy_o      (busy_o),
    .sel_err_o   (sel_err_o),
    .tcsm_viol_o (tcsm_viol_o)
  );

  always #5 tx_clk_90 = ~tx_clk_90;

  typedef struct {
    logic [1:0] cs;
    logic       ena;
    logic       ck;
    logic [1:0] csn;
    logic       cke;
    logic       rdy;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] cs, input logic ena, input logic ck,
                     input logic [1:0] csn, input logic cke, input logic rdy,
                     input logic busy, input logic err);
    vec_t v;
    v.cs = cs; v.ena = ena; v.ck = ck;
    v.csn = csn; v.cke = cke; v.rdy = rdy; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge tx_clk_90);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    cs_i         = 2'b00;
    cs_ena_i     = 1'b0;
    ck_req_i     = 1'b0;
    cfg_t_css_i  = 4'd2;
    cfg_t_csh_i  = 4'd3;
    cfg_t_cshi_i = 4'd1;
    cfg_t_csm_i  = 12'd0;

    //   cs     ena   ck    csn    cke   rdy   busy  err
    add(2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2'b01, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0); // CS low at edge 1
    add(2'b01, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0); // cs_i change ignored
    add(2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0); // ready at edge 4
    add(2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    add(2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    add(2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0); // HOLD, ck_req ignored
    add(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0); // CS high, RECOVER
    add(2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0); // request ignored
    add(2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); // IDLE
    add(2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0); // CS-high = cshi+2
    add(2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0); // abort from SETUP
    add(2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1); // multi-hot
    add(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    add(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    add(2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1); // zero-hot
    add(2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge tx_clk_90);
    #1;
    chk("rst_csn",  hyper_cs_no, 2'b11);
    chk("rst_cke",  ck_ena_o,    1'b0);
    chk("rst_rdy",  cs_ready_o,  1'b0);
    chk("rst_busy", busy_o,      1'b0);
    chk("rst_err",  sel_err_o,   1'b0);
    chk("rst_viol", tcsm_viol_o, 1'b0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cs_i     = vecs[i].cs;
      cs_ena_i = vecs[i].ena;
      ck_req_i = vecs[i].ck;
      step();
      chk($sformatf("v%0d_csn", i),  hyper_cs_no, vecs[i].csn);
      chk($sformatf("v%0d_cke", i),  ck_ena_o,    vecs[i].cke);
      chk($sformatf("v%0d_rdy", i),  cs_ready_o,  vecs[i].rdy);
      chk($sformatf("v%0d_busy", i), busy_o,      vecs[i].busy);
      chk($sformatf("v%0d_err", i),  sel_err_o,   vecs[i].err);
      chk($sformatf("v%0d_viol", i), tcsm_viol_o, 1'b0);
    end

    // Abort one cycle after CS low with a long setup
    cfg_t_css_i = 4'd5; cfg_t_csh_i = 4'd1; cfg_t_cshi_i = 4'd0;
    cs_i = 2'b01; cs_ena_i = 1'b1;
    step();
    chk("ab_csn_low", hyper_cs_no, 2'b10);
    cs_ena_i = 1'b0;
    step();
    chk("ab_hold_csn", hyper_cs_no, 2'b10);
    chk("ab_hold_rdy", cs_ready_o, 1'b0);
    step();
    chk("ab_hold2_csn", hyper_cs_no, 2'b10);
    chk("ab_hold2_rdy", cs_ready_o, 1'b0);
    step();
    chk("ab_rec_csn", hyper_cs_no, 2'b11);
    chk("ab_rec_busy", busy_o, 1'b1);
    chk("ab_rec_rdy", cs_ready_o, 1'b0);
    step();
    chk("ab_idle_busy", busy_o, 1'b0);

    // Asynchronous reset while in HOLD
    cfg_t_css_i = 4'd0; cfg_t_csh_i = 4'd5;
    cs_i = 2'b01; cs_ena_i = 1'b1;
    step();
    step();
    chk("ar_rdy", cs_ready_o, 1'b1);
    ck_req_i = 1'b1;
    step();
    chk("ar_cke", ck_ena_o, 1'b1);
    cs_ena_i = 1'b0; ck_req_i = 1'b0;
    step();
    step();
    chk("ar_hold_csn", hyper_cs_no, 2'b10);
    rst_ni = 1'b0;
    #1;
    chk("ar_async_csn",  hyper_cs_no, 2'b11);
    chk("ar_async_cke",  ck_ena_o,    1'b0);
    chk("ar_async_busy", busy_o,      1'b0);
    step();
    step();
    rst_ni = 1'b1;
    cfg_t_csh_i = 4'd0; cfg_t_cshi_i = 4'd0;
    cs_i = 2'b10; cs_ena_i = 1'b1;
    step();
    chk("ar_new_csn", hyper_cs_no, 2'b01);
    step();
    chk("ar_new_rdy", cs_ready_o, 1'b1);
    cs_ena_i = 1'b0;
    step();
    chk("ar_new_hold", hyper_cs_no, 2'b01);
    step();
    chk("ar_new_csh", hyper_cs_no, 2'b11);
    step();
    chk("ar_new_idle", busy_o, 1'b0);

    // tCSM watchdog: flag appears once CS has been low for 10 cycles
    cfg_t_csm_i = 12'd10;
    cs_i = 2'b01; cs_ena_i = 1'b1;
    step();
    chk("wd_e1", tcsm_viol_o, 1'b0);
    for (int k = 2; k <= 20; k++) begin
      step();
      chk($sformatf("wd_e%0d", k), tcsm_viol_o, (TcsmOn && k >= 11) ? 1'b1 : 1'b0);
    end
    cs_ena_i = 1'b0;
    step();
    step();
    step();
    chk("wd_idle_busy", busy_o, 1'b0);
    chk("wd_idle_viol", tcsm_viol_o, TcsmOn);
    cs_ena_i = 1'b1;
    step();
    chk("wd_reselect_csn",  hyper_cs_no, 2'b10);
    chk("wd_reselect_viol", tcsm_viol_o, 1'b0);
    cs_ena_i = 1'b0;
    repeat (4) step();
    chk("wd_end_busy", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
